// File: rtl/fastdac_ram_player.sv
// rtl/fastdac_ram_player.sv - read-side sequencer streaming waveform RAM words to the DAC serializer
// Optional underrun counter output enabled by defining FASTDAC_UNDERRUN_CNT_EN.
module fastdac_ram_player #(
  parameter int WIDTHB     = 16,
  parameter int ADDRWIDTHB = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cont,
  input  logic [ADDRWIDTHB-1:0] start_addr,
  input  logic [ADDRWIDTHB-1:0] len_m1,
  output logic                  ram_en,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  input  logic [WIDTHB-1:0]     ram_dout,
  output logic [WIDTHB-1:0]     m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  done
`ifdef FASTDAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_cont;
  logic [ADDRWIDTHB-1:0] r_start_addr, r_len_m1, r_addr, r_k;
  logic                  r_inflight;
  logic [WIDTHB-1:0]     r_mem [2];
  logic                  r_rd_ptr, r_wr_ptr;
  logic [1:0]            r_count;
  logic                  w_pop, w_start_ok, w_last;

  assign w_pop      = m_tvalid & m_tready;
  assign w_start_ok = (r_state == S_IDLE) & start;
  assign w_last     = (r_k == r_len_m1);
  assign m_tvalid   = (r_count != 2'd0);
  assign m_tdata    = r_mem[r_rd_ptr];
  assign ram_addr   = r_addr;
  assign busy       = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);

  // Issue only if the word will still have a FIFO slot after this cycle's pop.
  assign ram_en = (r_state == S_RUN) &&
                  (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (stop || (ram_en && w_last && !r_cont)) w_next = S_DRAIN;
      S_DRAIN: if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                 w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cont       <= 1'b0;
      r_start_addr <= '0;
      r_len_m1     <= '0;
      r_addr       <= '0;
      r_k          <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= ram_en;
      if (w_start_ok) begin
        r_cont       <= cont;
        r_start_addr <= start_addr;
        r_len_m1     <= len_m1;
        r_addr       <= start_addr;
        r_k          <= '0;
      end else if (ram_en) begin
        if (w_last && r_cont) begin
          r_addr <= r_start_addr;
          r_k    <= '0;
        end else begin
          r_addr <= r_addr + ADDRWIDTHB'(1);
          r_k    <= r_k + ADDRWIDTHB'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= ram_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

`ifdef FASTDAC_UNDERRUN_CNT_EN
  logic [1:0] r_warm;

  // The first two busy cycles are pipeline fill, not starvation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_warm       <= 2'd0;
      underrun_cnt <= 16'd0;
    end else if (w_start_ok) begin
      r_warm       <= 2'd0;
      underrun_cnt <= 16'd0;
    end else if (busy) begin
      if (r_warm != 2'd2)
        r_warm <= r_warm + 2'd1;
      else if (m_tready && !m_tvalid && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fastdac_ram_player.sv
// tb/tb_fastdac_ram_player.sv - scoreboard bench for fastdac_ram_player
module tb_fastdac_ram_player;

  logic        clk = 1'b0;
  logic        rstn, start, stop, cont, ram_en, m_tvalid, m_tready, busy, done;
  logic [7:0]  start_addr, len_m1, ram_addr;
  logic [15:0] ram_dout, m_tdata;
`ifdef FASTDAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_chk = 0, n_err = 0;
  int n_rd = 0, n_hs = 0, n_done = 0;
  logic [7:0]  addr_q [$];
  logic [15:0] data_q [$];
  logic [7:0]  exp_a;
  logic [15:0] exp_d;

  always #5 clk = ~clk;

  fastdac_ram_player dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .cont(cont),
    .start_addr(start_addr), .len_m1(len_m1), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .done(done)
`ifdef FASTDAC_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always @(posedge clk) if (ram_en) ram_dout <= {8'h00, ram_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rstn) begin
    if (ram_en) begin
      n_rd++;
      if (addr_q.size() == 0) check("extra_read", addr_q.size(), 1);
      else begin
        exp_a = addr_q.pop_front();
        check("ram_addr", ram_addr, exp_a);
      end
    end
    if (m_tvalid && m_tready) begin
      n_hs++;
      if (data_q.size() == 0) check("extra_word", data_q.size(), 1);
      else begin
        exp_d = data_q.pop_front();
        check("m_tdata", m_tdata, exp_d);
      end
    end
    if (done) n_done++;
  end

  task automatic push_exp(input logic [7:0] sa, input logic [7:0] len, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = sa + 8'(i % (int'(len) + 1));
      addr_q.push_back(a);
      data_q.push_back({8'h00, a});
    end
  endtask

  task automatic pulse_start(input logic [7:0] sa, input logic [7:0] len, input logic c);
    @(posedge clk); #1;
    start_addr = sa; len_m1 = len; cont = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int waited);
    waited = 0;
    while (!done && waited < max) begin
      @(negedge clk);
      waited++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  int w, rd0, hs0, dn0;

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    start_addr = '0; len_m1 = '0; m_tready = 1'b0;
    @(negedge clk);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rstn = 1'b1;

    // One-shot, no backpressure, latency and gapless delivery
    m_tready = 1'b1; dn0 = n_done;
    push_exp(8'h10, 8'd3, 4);
    pulse_start(8'h10, 8'd3, 1'b0);
    @(negedge clk);
    check("t1_busy_c1", busy, 1);
    check("t1_ram_en_c1", ram_en, 1);
    check("t1_tvalid_c1", m_tvalid, 0);
    @(negedge clk);
    check("t1_tvalid_c2", m_tvalid, 0);
    @(negedge clk);
    check("t1_tvalid_c3", m_tvalid, 1);
    wait_done(20, w);
    check("t1_done_lat", w, 4);
    check("t1_busy_at_done", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    idle_cycles(2);
    check("t1_done_cnt", n_done - dn0, 1);
    check("t1_sb_empty", data_q.size(), 0);

    // Address window wrapping past the top
    dn0 = n_done;
    push_exp(8'hFE, 8'd3, 4);
    pulse_start(8'hFE, 8'd3, 1'b0);
    wait_done(30, w);
    idle_cycles(2);
    check("t2_done_cnt", n_done - dn0, 1);
    check("t2_addr_empty", addr_q.size(), 0);
    check("t2_sb_empty", data_q.size(), 0);

    // Backpressure: toggling ready, then a held stall
    m_tready = 1'b0; rd0 = n_rd; hs0 = n_hs;
    push_exp(8'h30, 8'd7, 8);
    pulse_start(8'h30, 8'd7, 1'b0);
    for (int i = 0; i < 8; i++) begin
      m_tready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("t3_stall_ram_en", ram_en, 0);
        check("t3_stall_tvalid", m_tvalid, 1);
        check("t3_stall_tdata", m_tdata, 16'h0033);
      end
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_done(40, w);
    idle_cycles(2);
    check("t3_reads", n_rd - rd0, 8);
    check("t3_words", n_hs - hs0, 8);
    check("t3_sb_empty", data_q.size(), 0);

    // Continuous loop, stop after five accepted words
    rd0 = n_rd; hs0 = n_hs; dn0 = n_done;
    push_exp(8'h00, 8'd1, 8);
    pulse_start(8'h00, 8'd1, 1'b1);
    w = 0;
    while ((n_hs - hs0) < 5 && w < 30) begin
      @(negedge clk); #1;
      w++;
    end
    check("t4_five_words", n_hs - hs0, 5);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_done(20, w);
    check("t4_done_lat", w, 3);
    idle_cycles(6);
    check("t4_words", n_hs - hs0, 8);
    check("t4_reads_after_done", n_rd - rd0, 8);
    check("t4_done_cnt", n_done - dn0, 1);
    check("t4_sb_empty", data_q.size(), 0);
`ifdef FASTDAC_UNDERRUN_CNT_EN
    check("t4_underrun", underrun_cnt, 0);
`endif

    // Reset while the FIFO is full and stalled
    m_tready = 1'b0;
    push_exp(8'h40, 8'd1, 4);
    pulse_start(8'h40, 8'd1, 1'b1);
    idle_cycles(4);
    @(negedge clk);
    check("t5_full_tvalid", m_tvalid, 1);
    check("t5_full_tdata", m_tdata, 16'h0040);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_ram_en", ram_en, 0);
    check("t5_rst_ram_addr", ram_addr, 0);
    check("t5_rst_tdata", m_tdata, 0);
    check("t5_rst_tvalid", m_tvalid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    addr_q.delete();
    data_q.delete();
    @(negedge clk); rstn = 1'b1;
    rd0 = n_rd; dn0 = n_done; hs0 = n_hs;
    idle_cycles(4);
    check("t5_no_autostart_busy", busy, 0);
    check("t5_no_autostart_reads", n_rd - rd0, 0);
    m_tready = 1'b1;
    push_exp(8'h20, 8'd1, 2);
    pulse_start(8'h20, 8'd1, 1'b0);
    wait_done(20, w);
    idle_cycles(2);
    check("t5_new_words", n_hs - hs0, 2);
    check("t5_done_cnt", n_done - dn0, 1);
    check("t5_sb_empty", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
